// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage branch resolution, load-use detection and pipeline stall/flush control
module ex_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_func3,
  input  logic [4:0]       ex_rd_addr,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  typedef enum logic {RUN, REDIR} state_t;
  state_t           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic             eq, lt_s, lt_u, br_cond, taken, load_use, rs1_used, rs2_used;
  logic             redir, take_now;
  logic [31:0]      jalr_sum, target;
  // branch/jump decision and target for the EX instruction
  always_comb begin
    eq       = rs1_val == rs2_val;
    lt_s     = $signed(rs1_val) < $signed(rs2_val);
    lt_u     = rs1_val < rs2_val;
    br_cond  = ex_func3[2] ? (ex_func3[1] ? (lt_u ^ ex_func3[0]) : (lt_s ^ ex_func3[0]))
                           : (ex_func3[1] ? 1'b0 : (eq ^ ex_func3[0]));
    taken    = ex_valid & ((ex_opcode == OP_JAL) | (ex_opcode == OP_JALR) |
                           ((ex_opcode == OP_BRANCH) & br_cond));
    jalr_sum = rs1_val + ex_imm;
    target   = (ex_opcode == OP_JALR) ? {jalr_sum[31:1], 1'b0} : ex_pc + ex_imm;
  end
  // load-use hazard between the load in EX and the source operands of ID
  always_comb begin
    rs1_used = !((id_opcode == OP_LUI) | (id_opcode == OP_AUIPC) | (id_opcode == OP_JAL));
    rs2_used = (id_opcode == OP_BRANCH) | (id_opcode == OP_STORE) | (id_opcode == OP_OP);
    load_use = ex_valid & (ex_opcode == OP_LOAD) & (ex_rd_addr != 5'd0) & id_valid &
               ((rs1_used & (id_rs1_addr == ex_rd_addr)) | (rs2_used & (id_rs2_addr == ex_rd_addr)));
  end
  // control outputs are held low while reset is asserted
  always_comb begin
    redir          = state_q == REDIR;
    take_now       = !redir & !mem_busy & taken;
    pc_stall       = !rst_ & (mem_busy | (!redir & !taken & load_use));
    if_id_stall    = pc_stall;
    id_ex_stall    = !rst_ & mem_busy;
    if_id_flush    = !rst_ & (redir | take_now);
    id_ex_flush    = !rst_ & (redir | (!mem_busy & (taken | load_use)));
    redirect_valid = !rst_ & redir;
  end
  // next state, captured target and saturating counters
  always_comb begin
    state_d       = redir ? (mem_busy ? REDIR : RUN) : (take_now ? REDIR : RUN);
    redirect_pc_d = take_now ? target : redirect_pc_q;
    redir_cnt_d   = (take_now & ~&redir_cnt_q) ? redir_cnt_q + CNT_W'(1) : redir_cnt_q;
    stall_cnt_d   = (pc_stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q       <= RUN;
      redirect_pc_q <= '0;
      stall_cnt_q   <= '0;
      redir_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_d;
      redir_cnt_q   <= redir_cnt_d;
    end
  end
  assign redirect_pc = redirect_pc_q;
  assign stall_cnt   = stall_cnt_q;
  assign redir_cnt   = redir_cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: scoreboard bench for ex_hazard_ctrl with directed vectors
module tb_ex_hazard_ctrl;
  logic        clk, rst_;
  logic        ex_valid, id_valid, mem_busy;
  logic [31:0] ex_pc, ex_imm, rs1_val, rs2_val;
  logic [6:0]  ex_opcode, id_opcode;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_rd_addr, id_rs1_addr, id_rs2_addr;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cnt, redir_cnt;
  logic        p2, is2, if2, es2, ef2, rv2;
  logic [31:0] rpc2;
  logic [1:0]  sc2, rc2;
  int errors = 0, checks = 0;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LD = 7'b0000011;
  localparam logic [6:0] LUI = 7'b0110111, OP = 7'b0110011, OPI = 7'b0010011;
  localparam logic [5:0] NONE = 6'b000000, FL = 6'b001010, RD = 6'b001011;
  localparam logic [5:0] LU = 6'b110010, ST = 6'b110100, RDMB = 6'b111111;
  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic [31:0] rpc;
    logic [15:0] sc, rc;
    logic        c2;
    logic [1:0]  s2;
  } exp_t;
  exp_t q[$];
  ex_hazard_ctrl dut (
    .clk(clk), .rst_(rst_), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_rd_addr(ex_rd_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt));
  ex_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_(rst_), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_rd_addr(ex_rd_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .mem_busy(mem_busy),
    .pc_stall(p2), .if_id_stall(is2), .if_id_flush(if2),
    .id_ex_stall(es2), .id_ex_flush(ef2), .redirect_valid(rv2),
    .redirect_pc(rpc2), .stall_cnt(sc2), .redir_cnt(rc2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic r = 1'b0, input logic mb = 1'b0);
    rst_ = r; mem_busy = mb;
    ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_opcode = 0; ex_func3 = 0; ex_rd_addr = 0;
    rs1_val = 0; rs2_val = 0;
    id_valid = 0; id_opcode = 0; id_rs1_addr = 0; id_rs2_addr = 0;
  endtask
  task automatic ex(input logic v, input logic [31:0] pc, imm, input logic [6:0] op,
                    input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a, b);
    ex_valid = v; ex_pc = pc; ex_imm = imm; ex_opcode = op; ex_func3 = f3; ex_rd_addr = rd;
    rs1_val = a; rs2_val = b;
  endtask
  task automatic id(input logic v, input logic [6:0] op, input logic [4:0] r1, r2);
    id_valid = v; id_opcode = op; id_rs1_addr = r1; id_rs2_addr = r2;
  endtask
  task automatic expect_cyc(input string nm, input logic [5:0] c, input logic [31:0] p,
                            input logic [15:0] s, r, input logic c2 = 1'b0,
                            input logic [1:0] s2 = 2'd0);
    exp_t e;
    e.nm = nm; e.ctl = c; e.rpc = p; e.sc = s; e.rc = r; e.c2 = c2; e.s2 = s2;
    q.push_back(e);
  endtask
  // monitor: every cycle with a pending expectation compares the DUT away from the clock edge
  initial begin
    exp_t e;
    logic [5:0] ctl;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, redirect_valid};
        checks++;
        if ({ctl, redirect_pc, stall_cnt, redir_cnt} !== {e.ctl, e.rpc, e.sc, e.rc}) begin
          errors++;
          $display("FAIL %s: got ctl=%b rpc=%h sc=%0d rc=%0d, want ctl=%b rpc=%h sc=%0d rc=%0d",
                   e.nm, ctl, redirect_pc, stall_cnt, redir_cnt, e.ctl, e.rpc, e.sc, e.rc);
        end
        if (e.c2) begin
          checks++;
          if (sc2 !== e.s2) begin
            errors++;
            $display("FAIL %s_w2: got stall_cnt=%0d, want %0d", e.nm, sc2, e.s2);
          end
        end
      end
    end
  end
  initial begin
    idle(1'b1);
    tick(); idle(1'b1);                                   expect_cyc("reset", NONE, 0, 0, 0);
    tick(); idle();                                       expect_cyc("idle", NONE, 0, 0, 0);
    tick(); idle(); ex(1, 32'h100, 32'h20, BR, 3'b000, 0, 5, 5);
                                                          expect_cyc("beq_n", FL, 0, 0, 0);
    tick(); idle();                                       expect_cyc("beq_n1", RD, 32'h120, 0, 1);
    tick(); idle();                                       expect_cyc("beq_n2", NONE, 32'h120, 0, 1);
    tick(); idle(); ex(1, 32'h200, 32'h40, BR, 3'b100, 0, 32'hFFFF_FFFF, 1);
                                                          expect_cyc("blt", FL, 32'h120, 0, 1);
    tick(); idle();                                       expect_cyc("blt_redir", RD, 32'h240, 0, 2);
    tick(); idle(); ex(1, 32'h300, 32'h40, BR, 3'b110, 0, 32'hFFFF_FFFF, 1);
                                                          expect_cyc("bltu", NONE, 32'h240, 0, 2);
    tick(); idle();                                       expect_cyc("bltu_next", NONE, 32'h240, 0, 2);
    tick(); idle(); ex(1, 32'h400, 32'h4, JALR, 3'b000, 1, 32'h203, 0);
                                                          expect_cyc("jalr", FL, 32'h240, 0, 2);
    tick(); idle();                                       expect_cyc("jalr_redir", RD, 32'h206, 0, 3);
    tick(); idle(); ex(1, 32'h10, 32'hFFFF_FFF0, JAL, 3'b000, 1, 0, 0);
                                                          expect_cyc("jal", FL, 32'h206, 0, 3);
    tick(); idle();                                       expect_cyc("jal_redir", RD, 32'h0, 0, 4);
    tick(); idle(); ex(1, 32'h500, 0, LD, 3'b010, 5, 0, 0); id(1, OP, 1, 5);
                                                          expect_cyc("load_use", LU, 0, 0, 4);
    tick(); idle(); id(1, OP, 1, 5);                      expect_cyc("load_use_after", NONE, 0, 1, 4);
    tick(); idle(); ex(1, 32'h500, 0, LD, 3'b010, 5, 0, 0); id(1, LUI, 5, 0);
                                                          expect_cyc("lui_no_use", NONE, 0, 1, 4);
    tick(); idle(); ex(1, 32'h500, 0, LD, 3'b010, 0, 0, 0); id(1, OPI, 0, 0);
                                                          expect_cyc("load_rd0", NONE, 0, 1, 4);
    tick(); idle(); ex(0, 32'h700, 32'h8, BR, 3'b000, 0, 3, 3);
                                                          expect_cyc("invalid_br", NONE, 0, 1, 4);
    tick(); idle(1'b0, 1'b1); ex(1, 32'h600, 32'h8, BR, 3'b001, 0, 1, 2);
                                                          expect_cyc("bne_mb1", ST, 0, 1, 4);
    tick(); idle(1'b0, 1'b1); ex(1, 32'h600, 32'h8, BR, 3'b001, 0, 1, 2);
                                                          expect_cyc("bne_mb2", ST, 0, 2, 4);
    tick(); idle(1'b0, 1'b1); ex(1, 32'h600, 32'h8, BR, 3'b001, 0, 1, 2);
                                                          expect_cyc("bne_mb3", ST, 0, 3, 4);
    tick(); idle(); ex(1, 32'h600, 32'h8, BR, 3'b001, 0, 1, 2);
                                                          expect_cyc("bne_go", FL, 0, 4, 4);
    tick(); idle();                                       expect_cyc("bne_redir", RD, 32'h608, 4, 5);
    tick(); idle();                                       expect_cyc("bne_done", NONE, 32'h608, 4, 5);
    tick(); idle(); ex(1, 32'h20, 32'h10, JAL, 3'b000, 1, 0, 0);
                                                          expect_cyc("jal2", FL, 32'h608, 4, 5);
    tick(); idle(1'b0, 1'b1);                             expect_cyc("redir_mb1", RDMB, 32'h30, 4, 6);
    tick(); idle(1'b0, 1'b1);                             expect_cyc("redir_mb2", RDMB, 32'h30, 5, 6);
    tick(); idle();                                       expect_cyc("redir_rel", RD, 32'h30, 6, 6);
    tick(); idle();                                       expect_cyc("redir_done", NONE, 32'h30, 6, 6);
    tick(); idle(); ex(1, 32'h40, 32'h4, JAL, 3'b000, 1, 0, 0);
                                                          expect_cyc("jal3", FL, 32'h30, 6, 6);
    tick(); idle(1'b1);                                   expect_cyc("rst_in_redir", NONE, 32'h44, 6, 7);
    tick(); idle();                                       expect_cyc("post_rst", NONE, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); idle(1'b0, 1'b1);                           expect_cyc("sat_stall", ST, 0, 16'(i), 0);
    end
    tick(); idle();                                       expect_cyc("sat_end", NONE, 0, 5, 0, 1'b1, 2'd3);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
EX-stage control block that produces the stall/flush controls consumed by ID_EX, IF_ID and the PC register.
- Resolves branches and jumps for the instruction held in ID_EX.
- Registers the redirect target.
- Detects load-use hazards against the instruction in ID.
- Holds the whole front end while data memory is busy.
- Keeps saturating stall and redirect counters.

Parameters:
CNT_W, 16, width of the stall_cnt and redir_cnt performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_  in  1  synchronous, active-high reset (1 = reset)
ex_valid  in  1  EX instruction valid (from ID_EX)
ex_pc  in  32  EX instruction PC
ex_imm  in  32  EX sign-extended immediate
ex_opcode  in  7  EX opcode
ex_func3  in  3  EX func3
ex_rd_addr  in  5  EX destination register
rs1_val  in  32  forwarded rs1 operand for EX
rs2_val  in  32  forwarded rs2 operand for EX
id_valid  in  1  ID instruction valid
id_opcode  in  7  ID opcode
id_rs1_addr  in  5  ID rs1
id_rs2_addr  in  5  ID rs2
mem_busy  in  1  data memory not ready; hold the pipeline
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF_ID
if_id_flush  out  1  clear IF_ID
id_ex_stall  out  1  hold ID_EX (drives ID_EX stall)
id_ex_flush  out  1  clear ID_EX (drives ID_EX flush)
redirect_valid  out  1  redirect_pc is to be loaded into PC
redirect_pc  out  32  registered target
stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
redir_cnt  out  CNT_W  redirects issued, saturating

Behaviour:
- FSM states: RUN, REDIR. Reset: state=RUN, redirect_pc=0, stall_cnt=0, redir_cnt=0; all stall/flush/redirect outputs 0. Reset overrides everything, including mid-REDIR.
- Outputs: stall/flush outputs are combinational from state and inputs; redirect_valid = (state==REDIR).

Taken decision (ex_valid=1 required):
- BRANCH opcode 1100011, by func3:
  - 000: rs1==rs2
  - 001: rs1!=rs2
  - 100: signed rs1<rs2
  - 101: signed rs1>=rs2
  - 110: unsigned rs1<rs2
  - 111: unsigned rs1>=rs2
  - 010/011: never taken
- JAL 1101111: always taken; target = ex_pc+ex_imm.
- JALR 1100111: always taken; target = (rs1_val+ex_imm) with bit0 forced 0.
- Branch target = ex_pc+ex_imm. All additions are mod 2^32.

Load-use detection:
- Condition: ex_valid, ex_opcode==0000011, ex_rd_addr!=0, id_valid, and ex_rd_addr equals a used ID source.
- rs1 is used unless id_opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
- rs2 is used only for BRANCH 1100011, STORE 0100011, OP 0110011.

RUN, in priority order:
1. mem_busy=1:
   - pc_stall=if_id_stall=id_ex_stall=1; flushes 0.
   - Taken decision ignored; stay in RUN.
2. Taken:
   - if_id_flush=id_ex_flush=1; no stalls.
   - Register target into redirect_pc; redir_cnt+1; go to REDIR.
3. Load-use:
   - pc_stall=if_id_stall=1, id_ex_flush=1 (one bubble); id_ex_stall=0.
   - The next cycle naturally has no hazard (EX holds the bubble).
4. Otherwise all control outputs 0.

REDIR:
- redirect_valid=1, if_id_flush=1, id_ex_flush=1; EX contents ignored (bubble).
- If mem_busy=0: return to RUN next cycle; the redirect is one cycle wide.
- If mem_busy=1:
  - Also pc_stall=if_id_stall=id_ex_stall=1.
  - Flushes take precedence over stalls at the consumers.
  - Remain in REDIR with redirect_pc stable until mem_busy=0.
- Exactly one redirect and one redir_cnt increment per taken instruction.

Counters:
- stall_cnt increments each cycle pc_stall=1.
- Both counters saturate at 2^CNT_W-1 (no wrap).

Test Plan:
- BEQ, ex_pc=0x100, imm=0x20, rs1=rs2=5: cycle N if_id_flush=id_ex_flush=1; N+1 redirect_valid=1, redirect_pc=0x120, redir_cnt=1; N+2 redirect_valid=0.
- rs1=0xFFFFFFFF, rs2=1: BLT func3=100 gives a redirect; BLTU func3=110 gives all outputs 0, redir_cnt unchanged.
- JALR, rs1_val=0x203, imm=4 -> redirect_pc=0x206; JAL, ex_pc=0x10, imm=0xFFFFFFF0 -> redirect_pc=0x0.
- EX LOAD rd=5, ID ADD (0110011) rs2=5 -> exactly one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt=1.
  - Same with ID LUI rd-match on rs1: no stall.
  - EX LOAD rd=0 with ID rs1=0: no stall.
- Taken BNE in EX with mem_busy=1 for 3 cycles:
  - Full stall for 3 cycles, stall_cnt=3, no flush.
  - The cycle mem_busy falls: flushes asserted; next cycle a single redirect; redir_cnt=1.
- rst_=1 during REDIR -> next edge state RUN, redirect_valid=0, redirect_pc=0, counters 0.
- Separately, CNT_W=2 with 5 stall cycles -> stall_cnt=3.
